// File: rtl/gray_updown_counter_if.sv
// Control and status bundle for gray_updown_counter.
// The design side takes the slave modport; the sequencing logic that drives it takes master.
interface gray_updown_counter_if #(
  parameter int WIDTH = 3
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] gray;
  logic             tc;
  logic             evt;
  logic             sat;

  modport master (
    output en, up, load, load_val,
    input  count, gray, tc, evt, sat
  );

  modport slave (
    input  en, up, load, load_val,
    output count, gray, tc, evt, sat
  );
endinterface

// File: rtl/gray_updown_counter.sv
// Parametrised up/down counter with registered binary and Gray outputs, wrap or
// saturate at the boundaries, clamping synchronous load, and boundary flags.
module gray_updown_counter #(
  parameter int WIDTH    = 3,
  parameter int MODULUS  = 2**WIDTH,
  parameter bit SATURATE = 1'b0
) (
  input logic                  clk,
  input logic                  reset,
  gray_updown_counter_if.slave bus
);

  if (WIDTH < 1 || WIDTH > 31 || MODULUS < 2 || MODULUS > 2**WIDTH) begin : g_param_check
    $fatal(1, "gray_updown_counter: illegal WIDTH=%0d / MODULUS=%0d", WIDTH, MODULUS);
  end

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] gray_q;
  logic             evt_q;
  logic             sat_q;

  logic [WIDTH-1:0] count_d;
  logic             evt_d;
  logic             sat_d;
  logic             at_max;
  logic             at_zero;

  always_comb begin
    at_max  = (count_q == MAX);
    at_zero = (count_q == '0);
    count_d = count_q;
    evt_d   = 1'b0;
    sat_d   = sat_q;

    if (bus.load) begin
      count_d = (bus.load_val > MAX) ? MAX : bus.load_val;
      sat_d   = 1'b0;
    end else if (bus.en) begin
      if (bus.up) begin
        if (!at_max) begin
          count_d = count_q + WIDTH'(1);
          sat_d   = 1'b0;
        end else if (SATURATE) begin
          evt_d = 1'b1;
          sat_d = 1'b1;
        end else begin
          count_d = '0;
          evt_d   = 1'b1;
        end
      end else begin
        if (!at_zero) begin
          count_d = count_q - WIDTH'(1);
          sat_d   = 1'b0;
        end else if (SATURATE) begin
          evt_d = 1'b1;
          sat_d = 1'b1;
        end else begin
          count_d = MAX;
          evt_d   = 1'b1;
        end
      end
    end
  end

  // Gray is encoded from the next count so both registers update on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      gray_q  <= '0;
      evt_q   <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      gray_q  <= count_d ^ (count_d >> 1);
      evt_q   <= evt_d;
      sat_q   <= sat_d;
    end
  end

  always_comb begin
    bus.count = count_q;
    bus.gray  = gray_q;
    bus.evt   = evt_q;
    bus.sat   = sat_q;
    bus.tc    = bus.en & ~bus.load & (bus.up ? at_max : at_zero);
  end

endmodule

// File: tb/tb_gray_updown_counter.sv
// Directed table-driven bench for gray_updown_counter: default wrap counter,
// MODULUS=5 saturating counter and MODULUS=6 wrapping counter side by side.
module tb_gray_updown_counter;

  logic clk;
  logic reset;

  gray_updown_counter_if #(.WIDTH(3)) bus0 ();
  gray_updown_counter_if #(.WIDTH(3)) bus1 ();
  gray_updown_counter_if #(.WIDTH(3)) bus2 ();

  gray_updown_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(1'b0)) u0 (.clk(clk), .reset(reset), .bus(bus0));
  gray_updown_counter #(.WIDTH(3), .MODULUS(5), .SATURATE(1'b1)) u1 (.clk(clk), .reset(reset), .bus(bus1));
  gray_updown_counter #(.WIDTH(3), .MODULUS(6), .SATURATE(1'b0)) u2 (.clk(clk), .reset(reset), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         dut;
    logic       ld;
    logic       en;
    logic       up;
    logic [2:0] lv;
    logic [2:0] c;
    logic [2:0] g;
    logic       tc;
    logic       ev;
    logic       st;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic add(input int d, input logic ld, input logic en, input logic up,
                     input logic [2:0] lv, input logic [2:0] c, input logic [2:0] g,
                     input logic tc, input logic ev, input logic st);
    vec_t v;
    v.dut = d; v.ld = ld; v.en = en; v.up = up; v.lv = lv;
    v.c = c; v.g = g; v.tc = tc; v.ev = ev; v.st = st;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input int d, input logic ld, input logic en, input logic up, input logic [2:0] lv);
    bus0.load = 1'b0; bus0.en = 1'b0; bus0.up = 1'b0; bus0.load_val = '0;
    bus1.load = 1'b0; bus1.en = 1'b0; bus1.up = 1'b0; bus1.load_val = '0;
    bus2.load = 1'b0; bus2.en = 1'b0; bus2.up = 1'b0; bus2.load_val = '0;
    case (d)
      0: begin bus0.load = ld; bus0.en = en; bus0.up = up; bus0.load_val = lv; end
      1: begin bus1.load = ld; bus1.en = en; bus1.up = up; bus1.load_val = lv; end
      default: begin bus2.load = ld; bus2.en = en; bus2.up = up; bus2.load_val = lv; end
    endcase
  endtask

  task automatic get(input int d, output logic [2:0] c, output logic [2:0] g,
                     output logic tc, output logic ev, output logic st);
    case (d)
      0: begin c = bus0.count; g = bus0.gray; tc = bus0.tc; ev = bus0.evt; st = bus0.sat; end
      1: begin c = bus1.count; g = bus1.gray; tc = bus1.tc; ev = bus1.evt; st = bus1.sat; end
      default: begin c = bus2.count; g = bus2.gray; tc = bus2.tc; ev = bus2.evt; st = bus2.sat; end
    endcase
  endtask

  task automatic check_cleared(input int d, input string tag);
    logic [2:0] c, g;
    logic tc, ev, st;
    get(d, c, g, tc, ev, st);
    chk($sformatf("%s.u%0d.count", tag, d), int'(c), 0);
    chk($sformatf("%s.u%0d.gray", tag, d), int'(g), 0);
    chk($sformatf("%s.u%0d.event", tag, d), int'(ev), 0);
    chk($sformatf("%s.u%0d.sat", tag, d), int'(st), 0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [2:0] c, g;
    logic tc, ev, st;
    @(negedge clk);
    drive(v.dut, v.ld, v.en, v.up, v.lv);
    #1;
    get(v.dut, c, g, tc, ev, st);
    chk($sformatf("%s.u%0d.tc", tag, v.dut), int'(tc), int'(v.tc));
    @(posedge clk);
    #1;
    get(v.dut, c, g, tc, ev, st);
    chk($sformatf("%s.u%0d.count", tag, v.dut), int'(c), int'(v.c));
    chk($sformatf("%s.u%0d.gray", tag, v.dut), int'(g), int'(v.g));
    chk($sformatf("%s.u%0d.event", tag, v.dut), int'(ev), int'(v.ev));
    chk($sformatf("%s.u%0d.sat", tag, v.dut), int'(st), int'(v.st));
  endtask

  initial begin
    // Fields: dut, load, en, up, load_val | count, gray, tc(before edge), event, sat
    // u0: MODULUS=8 wrap, up through the wrap then down wrap and direction change
    add(0, 0, 1, 1, 0, 3'd1, 3'b001, 0, 0, 0);
    add(0, 0, 1, 1, 0, 3'd2, 3'b011, 0, 0, 0);
    add(0, 0, 1, 1, 0, 3'd3, 3'b010, 0, 0, 0);
    add(0, 0, 1, 1, 0, 3'd4, 3'b110, 0, 0, 0);
    add(0, 0, 1, 1, 0, 3'd5, 3'b111, 0, 0, 0);
    add(0, 0, 1, 1, 0, 3'd6, 3'b101, 0, 0, 0);
    add(0, 0, 1, 1, 0, 3'd7, 3'b100, 0, 0, 0);
    add(0, 0, 1, 1, 0, 3'd0, 3'b000, 1, 1, 0);
    add(0, 0, 1, 1, 0, 3'd1, 3'b001, 0, 0, 0);
    add(0, 1, 0, 0, 2, 3'd2, 3'b011, 0, 0, 0);
    add(0, 0, 1, 0, 0, 3'd1, 3'b001, 0, 0, 0);
    add(0, 0, 1, 0, 0, 3'd0, 3'b000, 0, 0, 0);
    add(0, 0, 1, 0, 0, 3'd7, 3'b100, 1, 1, 0);
    add(0, 0, 1, 1, 0, 3'd0, 3'b000, 1, 1, 0);
    add(0, 0, 0, 1, 0, 3'd0, 3'b000, 0, 0, 0);
    add(0, 1, 1, 1, 7, 3'd7, 3'b100, 0, 0, 0);
    add(0, 0, 0, 0, 0, 3'd7, 3'b100, 0, 0, 0);
    // u1: MODULUS=5 saturate, blocked steps, sat hold/clear, clamped load
    add(1, 1, 0, 0, 3, 3'd3, 3'b010, 0, 0, 0);
    add(1, 0, 1, 1, 0, 3'd4, 3'b110, 0, 0, 0);
    add(1, 0, 1, 1, 0, 3'd4, 3'b110, 1, 1, 1);
    add(1, 0, 1, 1, 0, 3'd4, 3'b110, 1, 1, 1);
    add(1, 0, 1, 1, 0, 3'd4, 3'b110, 1, 1, 1);
    add(1, 0, 1, 0, 0, 3'd3, 3'b010, 0, 0, 0);
    add(1, 0, 1, 1, 0, 3'd4, 3'b110, 0, 0, 0);
    add(1, 0, 1, 1, 0, 3'd4, 3'b110, 1, 1, 1);
    add(1, 0, 0, 1, 0, 3'd4, 3'b110, 0, 0, 1);
    add(1, 1, 1, 1, 7, 3'd4, 3'b110, 0, 0, 0);
    add(1, 1, 0, 0, 0, 3'd0, 3'b000, 0, 0, 0);
    add(1, 0, 1, 0, 0, 3'd0, 3'b000, 1, 1, 1);
    add(1, 1, 1, 0, 2, 3'd2, 3'b011, 0, 0, 0);
    // u2: MODULUS=6 wrap, multi-bit Gray change across the 5<->0 wrap
    add(2, 1, 0, 0, 4, 3'd4, 3'b110, 0, 0, 0);
    add(2, 0, 1, 1, 0, 3'd5, 3'b111, 0, 0, 0);
    add(2, 0, 1, 1, 0, 3'd0, 3'b000, 1, 1, 0);
    add(2, 0, 1, 1, 0, 3'd1, 3'b001, 0, 0, 0);
    add(2, 0, 1, 0, 0, 3'd0, 3'b000, 0, 0, 0);
    add(2, 0, 1, 0, 0, 3'd5, 3'b111, 1, 1, 0);
    add(2, 1, 0, 0, 7, 3'd5, 3'b111, 0, 0, 0);
    add(2, 0, 1, 1, 0, 3'd0, 3'b000, 1, 1, 0);

    reset = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) check_cleared(d, "rst");
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vq.size(); i++) run_vec(vq[i], $sformatf("v%0d", i));

    // Asynchronous reset between edges with u0 at 5 and u1 flagging a blocked step
    vq.delete();
    add(0, 1, 0, 0, 5, 3'd5, 3'b111, 0, 0, 0);
    add(1, 1, 0, 0, 4, 3'd4, 3'b110, 0, 0, 0);
    add(1, 0, 1, 1, 0, 3'd4, 3'b110, 1, 1, 1);
    for (int i = 0; i < vq.size(); i++) run_vec(vq[i], $sformatf("ar%0d", i));

    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    check_cleared(0, "async");
    check_cleared(1, "async");
    #1;
    reset = 1'b1;

    vq.delete();
    add(0, 0, 1, 1, 0, 3'd1, 3'b001, 0, 0, 0);
    add(1, 0, 1, 1, 0, 3'd1, 3'b001, 0, 0, 0);
    for (int i = 0; i < vq.size(); i++) run_vec(vq[i], $sformatf("post%0d", i));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
